// File: rtl/mem_loader.sv
// Byte-stream memory loader: a little-endian word count, then N 16-bit words written to memory.
// Define LOADER_CHECKSUM_EN to add a 16-bit wrapping-sum trailer check (csum_err).
module mem_loader #(
  parameter int WIDTH = 13,
  parameter int SIZE  = 8192
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             we,
  output logic [WIDTH-1:0] mem_din_addr,
  output logic [15:0]      mem_din,
  output logic             busy,
  output logic             done,
  output logic             len_err,
  output logic             csum_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM_LO, CSUM_HI, DONE
  } state_t;
  localparam state_t S_AFTER_DATA = CSUM_LO;
`else
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, DONE
  } state_t;
  localparam state_t S_AFTER_DATA = DONE;
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_len_lo;
  logic [15:0]        r_len;
  logic [7:0]         r_data_lo;
  logic [15:0]        r_word_cnt;
  logic               r_we;
  logic [WIDTH-1:0]   r_addr;
  logic [15:0]        r_din;
  logic               r_done;
  logic               r_len_err;

  logic               w_accept;
  logic               w_start_ok;
  logic               w_to_done;
  logic [15:0]        w_len;
  logic [15:0]        w_word;
  logic               w_last;
  logic               w_in_range;

  assign w_accept   = in_valid & in_ready;
  assign w_start_ok = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_len      = {in_byte, r_len_lo};
  assign w_word     = {in_byte, r_data_lo};
  // 17-bit compare so N=65535 cannot overflow the counter test
  assign w_last     = ({1'b0, r_word_cnt} + 17'd1) == {1'b0, r_len};
  assign w_in_range = {16'd0, r_word_cnt} < $unsigned(SIZE);
  assign w_to_done  = (w_state_next == DONE) & (r_state != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE:    if (start) w_state_next = LEN_LO;
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) w_state_next = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) w_state_next = (w_len == 16'd0) ? S_AFTER_DATA : DATA_LO;
      end
      DATA_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) w_state_next = DATA_HI;
      end
      DATA_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) w_state_next = w_last ? S_AFTER_DATA : DATA_LO;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) w_state_next = CSUM_HI;
      end
      CSUM_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) w_state_next = DONE;
      end
`endif
      DONE:    if (start) w_state_next = LEN_LO;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_lo   <= '0;
      r_len      <= '0;
      r_data_lo  <= '0;
      r_word_cnt <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_done     <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_word_cnt <= '0;
        r_done     <= 1'b0;
        r_len_err  <= 1'b0;
      end
      if (w_accept) begin
        case (r_state)
          LEN_LO:  r_len_lo <= in_byte;
          LEN_HI: begin
            r_len <= w_len;
            if ({16'd0, w_len} > $unsigned(SIZE)) r_len_err <= 1'b1;
          end
          DATA_LO: r_data_lo <= in_byte;
          DATA_HI: begin
            r_word_cnt <= r_word_cnt + 16'd1;
            // words past the end of memory are consumed silently
            if (w_in_range) begin
              r_we   <= 1'b1;
              r_addr <= WIDTH'(r_word_cnt);
              r_din  <= w_word;
            end
          end
          default: ;
        endcase
      end
      if (w_to_done) r_done <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_sum;
  logic [7:0]  r_csum_lo;
  logic        r_csum_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum      <= '0;
      r_csum_lo  <= '0;
      r_csum_err <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_sum      <= '0;
        r_csum_err <= 1'b0;
      end
      if (w_accept) begin
        case (r_state)
          DATA_HI: r_sum     <= r_sum + w_word;
          CSUM_LO: r_csum_lo <= in_byte;
          CSUM_HI: if ({in_byte, r_csum_lo} != r_sum) r_csum_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign csum_err = r_csum_err;
`else
  assign csum_err = 1'b0;
`endif

  assign we           = r_we;
  assign mem_din_addr = r_addr;
  assign mem_din      = r_din;
  assign done         = r_done;
  assign len_err      = r_len_err;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader (SIZE=4 so the overflow case is short); covers LOADER_CHECKSUM_EN when defined.
module tb_mem_loader;
  localparam int WIDTH = 13;
  localparam int SIZE  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_byte = 8'h00;
  logic             in_ready;
  logic             we;
  logic [WIDTH-1:0] mem_din_addr;
  logic [15:0]      mem_din;
  logic             busy;
  logic             done;
  logic             len_err;
  logic             csum_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  mem_loader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .we(we), .mem_din_addr(mem_din_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .len_err(len_err), .csum_err(csum_err)
  );

  always #5 clk = ~clk;

  // one queue entry per cycle with we high
  always @(negedge clk) begin
    if (rst_n && we) begin
      wr_addr.push_back(32'(mem_din_addr));
      wr_data.push_back(32'(mem_din));
      $display("write addr=%0d data=%04h", mem_din_addr, mem_din);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic do_start();
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_busy", 32'(busy), 1);
    check("start_done_clr", 32'(done), 0);
    check("start_lenerr_clr", 32'(len_err), 0);
  endtask

  task automatic send(input logic [7:0] b, input bit gap = 1'b0, input bit st = 1'b0);
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    start    = st;
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL in_ready got=0 expected=1 byte=%02h", b);
    end
  endtask

  task automatic end_load();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    #1;
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wr_addr.size()) begin
      check({tag, "_addr"}, wr_addr[idx], a);
      check({tag, "_data"}, wr_data[idx], d);
    end else begin
      check({tag, "_present"}, 0, 1);
    end
  endtask

  initial begin
    #2;
    check("rst_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_we", 32'(we), 0);
    check("rst_done", 32'(done), 0);
    check("rst_csum", 32'(csum_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // bytes offered while idle are ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("idle_ignore_busy", 32'(busy), 0);

    // basic two-word load
    do_start();
    send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'hCD); send(8'hAB);
`ifdef LOADER_CHECKSUM_EN
    send(8'h01); send(8'hBE);
`endif
    end_load();
    check("t1_done", 32'(done), 1);
    check("t1_busy", 32'(busy), 0);
    check("t1_nwr", wr_addr.size(), 2);
    check_write("t1_w0", 0, 0, 32'h1234);
    check_write("t1_w1", 1, 1, 32'hABCD);
    check("t1_lenerr", 32'(len_err), 0);
    check("t1_csum", 32'(csum_err), 0);
    @(negedge clk); #1;
    check("t1_hold_addr", 32'(mem_din_addr), 1);
    check("t1_hold_data", 32'(mem_din), 32'hABCD);

    // empty load
    do_start();
    send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00); send(8'h00);
`endif
    end_load();
    check("t2_done", 32'(done), 1);
    check("t2_nwr", wr_addr.size(), 0);
    check("t2_csum", 32'(csum_err), 0);

    // N=5 with SIZE=4: fifth word consumed, not written
    do_start();
    send(8'h05); send(8'h00);
    for (int i = 1; i <= 5; i++) begin
      send(8'(i)); send(8'(i));
    end
`ifdef LOADER_CHECKSUM_EN
    send(8'h0F); send(8'h0F);
`endif
    end_load();
    check("t3_lenerr", 32'(len_err), 1);
    check("t3_done", 32'(done), 1);
    check("t3_nwr", wr_addr.size(), 4);
    check_write("t3_w0", 0, 0, 32'h0101);
    check_write("t3_w3", 3, 3, 32'h0404);

    // reset between DATA_LO and DATA_HI
    do_start();
    send(8'h01); send(8'h00); send(8'h99);
    end_load();
    check("t4_pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_busy", 32'(busy), 0);
    check("t4_rst_ready", 32'(in_ready), 0);
    check("t4_rst_done", 32'(done), 0);
    check("t4_rst_lenerr", 32'(len_err), 0);
    check("t4_rst_addr", 32'(mem_din_addr), 0);
    check("t4_rst_data", 32'(mem_din), 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = 8'h88;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk); #1;
    check("t4_nwr", wr_addr.size(), 0);
    do_start();
    send(8'h01); send(8'h00); send(8'h78); send(8'h56);
`ifdef LOADER_CHECKSUM_EN
    send(8'h78); send(8'h56);
`endif
    end_load();
    check("t4_reload_done", 32'(done), 1);
    check("t4_reload_nwr", wr_addr.size(), 1);
    check_write("t4_reload_w0", 0, 0, 32'h5678);

    // gaps in in_valid plus a start pulse while busy
    do_start();
    send(8'h03, 1'b0); send(8'h00, 1'b1); send(8'h11, 1'b1); send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b1); send(8'h22, 1'b0); send(8'h33, 1'b1, 1'b1); send(8'h33, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send(8'h66, 1'b1); send(8'h66, 1'b0);
`endif
    end_load();
    check("t5_done", 32'(done), 1);
    check("t5_nwr", wr_addr.size(), 3);
    check_write("t5_w0", 0, 0, 32'h1111);
    check_write("t5_w1", 1, 1, 32'h2222);
    check_write("t5_w2", 2, 2, 32'h3333);

`ifdef LOADER_CHECKSUM_EN
    do_start();
    send(8'h02); send(8'h00); send(8'h01); send(8'h00); send(8'hFF); send(8'hFF);
    send(8'h00); send(8'h00);
    end_load();
    check("t6_csum_ok", 32'(csum_err), 0);
    do_start();
    send(8'h02); send(8'h00); send(8'h01); send(8'h00); send(8'hFF); send(8'hFF);
    send(8'h01); send(8'h00);
    end_load();
    check("t6_csum_bad", 32'(csum_err), 1);
    check("t6_done", 32'(done), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
